// File: rtl/sid_envelope_pkg.sv
// ---------------------------------------------------------------------------
// sid_envelope_pkg
// Shared types and constants for the SID per-voice ADSR envelope generator.
//   reg4_t          : 4-bit register nibble (AD / SR fields)
//   env_state_e     : envelope state encoding (3 is unused, decodes as release)
//   RATE_PERIOD     : 16-entry rate-counter period table
//   EXP_TH_*        : envelope levels where the exponential divider changes
//   exp_lookup()    : maps an envelope level to its exponential divider
// ---------------------------------------------------------------------------
package sid_envelope_pkg;

    typedef logic [3:0] reg4_t;

    typedef enum logic [1:0] {
        ST_ATTACK        = 2'd0,
        ST_DECAY_SUSTAIN = 2'd1,
        ST_RELEASE       = 2'd2
    } env_state_e;

    localparam int RATE_TABLE_W = 15;

    localparam logic [RATE_TABLE_W-1:0] RATE_PERIOD [16] = '{
        15'd9,    15'd32,   15'd63,   15'd95,
        15'd149,  15'd220,  15'd267,  15'd313,
        15'd392,  15'd977,  15'd1954, 15'd3126,
        15'd3907, 15'd11720, 15'd19532, 15'd31251
    };

    localparam logic [7:0] EXP_TH_1  = 8'hFF;
    localparam logic [7:0] EXP_TH_2  = 8'h5D;
    localparam logic [7:0] EXP_TH_4  = 8'h36;
    localparam logic [7:0] EXP_TH_8  = 8'h1A;
    localparam logic [7:0] EXP_TH_16 = 8'h0E;
    localparam logic [7:0] EXP_TH_30 = 8'h06;
    localparam logic [7:0] EXP_TH_0  = 8'h00;

    typedef struct packed {
        logic       hit;
        logic [4:0] period;
    } exp_sel_t;

    // Only the exact threshold levels produce a hit; between thresholds the
    // previously latched divider stays in force.
    function automatic exp_sel_t exp_lookup(input logic [7:0] env);
        exp_sel_t r;
        r.hit    = 1'b1;
        r.period = 5'd1;
        case (env)
            EXP_TH_1:  r.period = 5'd1;
            EXP_TH_2:  r.period = 5'd2;
            EXP_TH_4:  r.period = 5'd4;
            EXP_TH_8:  r.period = 5'd8;
            EXP_TH_16: r.period = 5'd16;
            EXP_TH_30: r.period = 5'd30;
            EXP_TH_0:  r.period = 5'd1;
            default:   r.hit    = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sid_envelope_if.sv
// ---------------------------------------------------------------------------
// sid_envelope_if
// Register-side bundle of one envelope voice.
//   active        : SID tick enable
//   gate          : control register GATE bit
//   attack/decay  : AD register nibbles
//   sustain/release_rate : SR register nibbles
//   envelope      : 8-bit envelope level (also the ENV3 read-back value)
//   state_o       : current envelope state for debug
// master drives the register side, slave is the envelope generator.
// ---------------------------------------------------------------------------
interface sid_envelope_if;
    import sid_envelope_pkg::*;

    logic       active;
    logic       gate;
    reg4_t      attack;
    reg4_t      decay;
    reg4_t      sustain;
    reg4_t      release_rate;
    logic [7:0] envelope;
    logic [1:0] state_o;

    modport master (
        output active, gate, attack, decay, sustain, release_rate,
        input  envelope, state_o
    );

    modport slave (
        input  active, gate, attack, decay, sustain, release_rate,
        output envelope, state_o
    );

endinterface

// File: rtl/sid_env_rate.sv
// ---------------------------------------------------------------------------
// sid_env_rate
// Rate counter of the envelope generator. Counts active ticks and fires
// rate_tick when the incremented count equals the selected period.
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : tick enable; counter holds when low
//   rate_sel   : 4-bit index into the rate period table
//   rate_tick  : combinational, high in the active cycle where the count
//                matches the period (counter returns to 0 on that edge)
// ---------------------------------------------------------------------------
module sid_env_rate
    import sid_envelope_pkg::*;
#(
    parameter int RATE_BITS = 15
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  active,
    input  reg4_t rate_sel,
    output logic  rate_tick
);

    logic [RATE_BITS-1:0] rate_counter;
    logic [RATE_BITS-1:0] nxt;
    logic [RATE_BITS-1:0] period;

    assign period = RATE_BITS'(RATE_PERIOD[rate_sel]);
    assign nxt    = rate_counter + RATE_BITS'(1);

    // Equality compare only: lowering the period below the current count
    // makes the counter run all the way around the wrap, as on the chip.
    assign rate_tick = active && (nxt == period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_counter <= '0;
        end else if (active) begin
            rate_counter <= rate_tick ? '0 : nxt;
        end
    end

endmodule

// File: rtl/sid_envelope.sv
// ---------------------------------------------------------------------------
// sid_envelope
// Per-voice ADSR envelope generator with MOS6581/8580 cycle behaviour:
// rate-counter wrap bug, piecewise exponential decay and zero-hold.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sid_envelope_if.slave (active, gate, ADSR nibbles in;
//                envelope level and state out, both registered)
// Parameters:
//   RATE_BITS  : rate counter width (wraps modulo 2^RATE_BITS)
//   ENV_INIT   : envelope level loaded on reset
// ---------------------------------------------------------------------------
module sid_envelope
    import sid_envelope_pkg::*;
#(
    parameter int         RATE_BITS = 15,
    parameter logic [7:0] ENV_INIT  = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    sid_envelope_if.slave  bus
);

    env_state_e state;
    logic [7:0] envelope_q;
    logic       hold_zero;
    logic       gate_prev;
    logic [4:0] exp_counter;
    logic [4:0] exp_period;

    reg4_t      rate_sel;
    logic       rate_tick;
    exp_sel_t   exp_sel;
    logic [4:0] exp_next;
    logic [4:0] exp_counter_d;
    logic       env_step;
    logic       gate_rise;
    logic       gate_fall;
    logic [7:0] sustain_level;

    // Period nibble follows the current (registered) state; encoding 3
    // falls through to the release nibble.
    always_comb begin
        rate_sel = bus.release_rate;
        case (state)
            ST_ATTACK:        rate_sel = bus.attack;
            ST_DECAY_SUSTAIN: rate_sel = bus.decay;
            default:          rate_sel = bus.release_rate;
        endcase
    end

    sid_env_rate #(
        .RATE_BITS (RATE_BITS)
    ) u_rate (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (bus.active),
        .rate_sel  (rate_sel),
        .rate_tick (rate_tick)
    );

    assign exp_sel       = exp_lookup(envelope_q);
    assign exp_next      = exp_counter + 5'd1;
    assign gate_rise     = bus.gate & ~gate_prev;
    assign gate_fall     = ~bus.gate & gate_prev;
    assign sustain_level = {bus.sustain, bus.sustain};

    // Exponential divider: attack and divider 1 step on every rate tick,
    // otherwise a step fires once every exp_period rate ticks.
    always_comb begin
        env_step      = 1'b0;
        exp_counter_d = exp_counter;
        if (rate_tick) begin
            if (state == ST_ATTACK || exp_period == 5'd1) begin
                env_step      = 1'b1;
                exp_counter_d = 5'd0;
            end else if (exp_next == exp_period) begin
                env_step      = 1'b1;
                exp_counter_d = 5'd0;
            end else begin
                exp_counter_d = exp_next;
            end
        end
    end

    // Envelope state machine. The step uses the state held before this edge;
    // gate edges are assigned last so they override any state change made
    // by the step in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            envelope_q  <= ENV_INIT;
            state       <= ST_RELEASE;
            exp_counter <= 5'd0;
            exp_period  <= 5'd1;
            hold_zero   <= 1'b1;
            gate_prev   <= 1'b0;
        end else if (bus.active) begin
            gate_prev   <= bus.gate;
            exp_counter <= exp_counter_d;
            if (exp_sel.hit) begin
                exp_period <= exp_sel.period;
            end
            if (env_step && !hold_zero) begin
                case (state)
                    ST_ATTACK: begin
                        envelope_q <= envelope_q + 8'd1;
                        if (envelope_q == 8'hFE) begin
                            state <= ST_DECAY_SUSTAIN;
                        end
                    end
                    ST_DECAY_SUSTAIN: begin
                        if (envelope_q != sustain_level && envelope_q != 8'h00) begin
                            envelope_q <= envelope_q - 8'd1;
                            if (envelope_q == 8'h01) begin
                                hold_zero <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (envelope_q != 8'h00) begin
                            envelope_q <= envelope_q - 8'd1;
                            if (envelope_q == 8'h01) begin
                                hold_zero <= 1'b1;
                            end
                        end
                    end
                endcase
            end
            if (gate_rise) begin
                state     <= ST_ATTACK;
                hold_zero <= 1'b0;
            end else if (gate_fall) begin
                state <= ST_RELEASE;
            end
        end
    end

    assign bus.envelope = envelope_q;
    assign bus.state_o  = state;

endmodule

// File: tb/tb_sid_envelope.sv
// ---------------------------------------------------------------------------
// tb_sid_envelope
// Directed testbench for sid_envelope: reset, attack, decay/sustain,
// release with exponential spacing and zero-hold, active gating with a
// sustain raise, asynchronous reset mid-attack and the rate-counter wrap.
// ---------------------------------------------------------------------------
module tb_sid_envelope;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    sid_envelope_if bus ();

    sid_envelope dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic advance(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.active = 1'b1;
        bus.gate = 1'b0;
        bus.attack = 4'h0;
        bus.decay = 4'h0;
        bus.sustain = 4'hA;
        bus.release_rate = 4'h0;
        advance(3);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL reset_env: got %h want %h", bus.envelope, 8'h00); end
        checks++; if (bus.state_o !== 2'd2) begin fails++; $display("[TB] FAIL reset_state: got %0d want %0d", bus.state_o, 2); end
        rst_n = 1'b1;
        bus.gate = 1'b1;
    endtask

    task automatic test_attack();
        advance(8);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL attack_pre: got %h want %h", bus.envelope, 8'h00); end
        advance(1);
        checks++; if (bus.envelope !== 8'h01) begin fails++; $display("[TB] FAIL attack_first: got %h want %h", bus.envelope, 8'h01); end
        checks++; if (bus.state_o !== 2'd0) begin fails++; $display("[TB] FAIL attack_state: got %0d want %0d", bus.state_o, 0); end
        advance(2285);
        checks++; if (bus.envelope !== 8'hFE) begin fails++; $display("[TB] FAIL attack_fe: got %h want %h", bus.envelope, 8'hFE); end
        checks++; if (bus.state_o !== 2'd0) begin fails++; $display("[TB] FAIL attack_fe_state: got %0d want %0d", bus.state_o, 0); end
        advance(1);
        checks++; if (bus.envelope !== 8'hFF) begin fails++; $display("[TB] FAIL attack_ff: got %h want %h", bus.envelope, 8'hFF); end
        checks++; if (bus.state_o !== 2'd1) begin fails++; $display("[TB] FAIL attack_to_ds: got %0d want %0d", bus.state_o, 1); end
    endtask

    task automatic test_decay_sustain();
        advance(9);
        checks++; if (bus.envelope !== 8'hFE) begin fails++; $display("[TB] FAIL decay_first: got %h want %h", bus.envelope, 8'hFE); end
        advance(755);
        checks++; if (bus.envelope !== 8'hAB) begin fails++; $display("[TB] FAIL decay_ab: got %h want %h", bus.envelope, 8'hAB); end
        advance(1);
        checks++; if (bus.envelope !== 8'hAA) begin fails++; $display("[TB] FAIL decay_aa: got %h want %h", bus.envelope, 8'hAA); end
        advance(198);
        checks++; if (bus.envelope !== 8'hAA) begin fails++; $display("[TB] FAIL sustain_hold: got %h want %h", bus.envelope, 8'hAA); end
        checks++; if (bus.state_o !== 2'd1) begin fails++; $display("[TB] FAIL sustain_state: got %0d want %0d", bus.state_o, 1); end
    endtask

    task automatic test_release();
        bus.gate = 1'b0;
        advance(8);
        checks++; if (bus.envelope !== 8'hAA) begin fails++; $display("[TB] FAIL release_pre: got %h want %h", bus.envelope, 8'hAA); end
        checks++; if (bus.state_o !== 2'd2) begin fails++; $display("[TB] FAIL release_state: got %0d want %0d", bus.state_o, 2); end
        advance(1);
        checks++; if (bus.envelope !== 8'hA9) begin fails++; $display("[TB] FAIL release_first: got %h want %h", bus.envelope, 8'hA9); end
        advance(684);
        checks++; if (bus.envelope !== 8'h5D) begin fails++; $display("[TB] FAIL release_5d: got %h want %h", bus.envelope, 8'h5D); end
        advance(17);
        checks++; if (bus.envelope !== 8'h5D) begin fails++; $display("[TB] FAIL release_5d_hold: got %h want %h", bus.envelope, 8'h5D); end
        advance(1);
        checks++; if (bus.envelope !== 8'h5C) begin fails++; $display("[TB] FAIL release_5c: got %h want %h", bus.envelope, 8'h5C); end
        advance(2412);
        checks++; if (bus.envelope !== 8'h10) begin fails++; $display("[TB] FAIL release_10: got %h want %h", bus.envelope, 8'h10); end
        advance(71);
        checks++; if (bus.envelope !== 8'h10) begin fails++; $display("[TB] FAIL release_10_hold: got %h want %h", bus.envelope, 8'h10); end
        advance(1);
        checks++; if (bus.envelope !== 8'h0F) begin fails++; $display("[TB] FAIL release_0f: got %h want %h", bus.envelope, 8'h0F); end
        advance(72);
        checks++; if (bus.envelope !== 8'h0E) begin fails++; $display("[TB] FAIL release_0e: got %h want %h", bus.envelope, 8'h0E); end
        advance(143);
        checks++; if (bus.envelope !== 8'h0E) begin fails++; $display("[TB] FAIL release_0e_hold: got %h want %h", bus.envelope, 8'h0E); end
        advance(1);
        checks++; if (bus.envelope !== 8'h0D) begin fails++; $display("[TB] FAIL release_0d: got %h want %h", bus.envelope, 8'h0D); end
        advance(2627);
        checks++; if (bus.envelope !== 8'h01) begin fails++; $display("[TB] FAIL release_01: got %h want %h", bus.envelope, 8'h01); end
        advance(1);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL release_00: got %h want %h", bus.envelope, 8'h00); end
        advance(2007);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL zero_hold: got %h want %h", bus.envelope, 8'h00); end
        checks++; if (bus.state_o !== 2'd2) begin fails++; $display("[TB] FAIL zero_hold_state: got %0d want %0d", bus.state_o, 2); end
    endtask

    task automatic test_gating_sustain_raise();
        bus.sustain = 4'h5;
        bus.gate = 1'b1;
        advance(9);
        checks++; if (bus.envelope !== 8'h01) begin fails++; $display("[TB] FAIL regate_first: got %h want %h", bus.envelope, 8'h01); end
        advance(2286);
        checks++; if (bus.envelope !== 8'hFF) begin fails++; $display("[TB] FAIL regate_ff: got %h want %h", bus.envelope, 8'hFF); end
        advance(1458);
        checks++; if (bus.envelope !== 8'h5D) begin fails++; $display("[TB] FAIL decay_5d: got %h want %h", bus.envelope, 8'h5D); end
        advance(17);
        checks++; if (bus.envelope !== 8'h5D) begin fails++; $display("[TB] FAIL decay_5d_hold: got %h want %h", bus.envelope, 8'h5D); end
        advance(1);
        checks++; if (bus.envelope !== 8'h5C) begin fails++; $display("[TB] FAIL decay_5c: got %h want %h", bus.envelope, 8'h5C); end
        advance(126);
        checks++; if (bus.envelope !== 8'h55) begin fails++; $display("[TB] FAIL decay_55: got %h want %h", bus.envelope, 8'h55); end
        bus.active = 1'b0;
        bus.sustain = 4'hF;
        advance(500);
        checks++; if (bus.envelope !== 8'h55) begin fails++; $display("[TB] FAIL inactive_env: got %h want %h", bus.envelope, 8'h55); end
        checks++; if (bus.state_o !== 2'd1) begin fails++; $display("[TB] FAIL inactive_state: got %0d want %0d", bus.state_o, 1); end
        bus.active = 1'b1;
        advance(17);
        checks++; if (bus.envelope !== 8'h55) begin fails++; $display("[TB] FAIL raise_pre: got %h want %h", bus.envelope, 8'h55); end
        advance(1);
        checks++; if (bus.envelope !== 8'h54) begin fails++; $display("[TB] FAIL raise_54: got %h want %h", bus.envelope, 8'h54); end
        advance(540);
        checks++; if (bus.envelope !== 8'h36) begin fails++; $display("[TB] FAIL raise_36: got %h want %h", bus.envelope, 8'h36); end
        advance(4643);
        checks++; if (bus.envelope !== 8'h01) begin fails++; $display("[TB] FAIL raise_01: got %h want %h", bus.envelope, 8'h01); end
        advance(1);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL raise_00: got %h want %h", bus.envelope, 8'h00); end
        advance(500);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL raise_hold: got %h want %h", bus.envelope, 8'h00); end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        bus.gate = 1'b0;
        bus.attack = 4'h0;
        bus.release_rate = 4'h0;
        #2;
        rst_n = 1'b1;
        bus.gate = 1'b1;
        advance(576);
        checks++; if (bus.envelope !== 8'h40) begin fails++; $display("[TB] FAIL midattack_40: got %h want %h", bus.envelope, 8'h40); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL async_env: got %h want %h", bus.envelope, 8'h00); end
        checks++; if (bus.state_o !== 2'd2) begin fails++; $display("[TB] FAIL async_state: got %0d want %0d", bus.state_o, 2); end
        bus.gate = 1'b0;
        #1;
        rst_n = 1'b1;
        advance(99);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL postreset_idle: got %h want %h", bus.envelope, 8'h00); end
        checks++; if (bus.state_o !== 2'd2) begin fails++; $display("[TB] FAIL postreset_state: got %0d want %0d", bus.state_o, 2); end
        bus.gate = 1'b1;
        advance(8);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL restart_pre: got %h want %h", bus.envelope, 8'h00); end
        advance(1);
        checks++; if (bus.envelope !== 8'h01) begin fails++; $display("[TB] FAIL restart_first: got %h want %h", bus.envelope, 8'h01); end
        checks++; if (bus.state_o !== 2'd0) begin fails++; $display("[TB] FAIL restart_state: got %0d want %0d", bus.state_o, 0); end
    endtask

    task automatic test_wrap_bug();
        rst_n = 1'b0;
        bus.gate = 1'b0;
        bus.attack = 4'hF;
        bus.release_rate = 4'h0;
        #2;
        rst_n = 1'b1;
        bus.gate = 1'b1;
        advance(1000);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL slow_attack: got %h want %h", bus.envelope, 8'h00); end
        checks++; if (bus.state_o !== 2'd0) begin fails++; $display("[TB] FAIL slow_attack_state: got %0d want %0d", bus.state_o, 0); end
        bus.attack = 4'h0;
        advance(9);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL wrap_no_early: got %h want %h", bus.envelope, 8'h00); end
        advance(31767);
        checks++; if (bus.envelope !== 8'h00) begin fails++; $display("[TB] FAIL wrap_pre: got %h want %h", bus.envelope, 8'h00); end
        advance(1);
        checks++; if (bus.envelope !== 8'h01) begin fails++; $display("[TB] FAIL wrap_tick: got %h want %h", bus.envelope, 8'h01); end
        advance(9);
        checks++; if (bus.envelope !== 8'h02) begin fails++; $display("[TB] FAIL wrap_after: got %h want %h", bus.envelope, 8'h02); end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        test_reset();
        test_attack();
        test_decay_sustain();
        test_release();
        test_gating_sustain_raise();
        test_async_reset();
        test_wrap_bug();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
